axis_realign_arb: RTL and testbench

//  Packet-level round-robin arbiter that shares one axis_realign instance among N AXI-Stream sources.

---
 rtl/axis_pkg.sv | 33 +++
 rtl/axis_skid.sv | 49 ++++
 rtl/axis_realign_arb.sv | 147 ++++++++++++++
 tb/tb_axis_realign_arb.sv | 494 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_pkg.sv
// Shared AXI-Stream definitions: fixed bus widths, arbiter state encoding and
// the round-robin winner search used by the packet arbiter.
package axis_pkg;

    localparam int AXIS_DATA_W = 32;
    localparam int AXIS_KEEP_W = 4;
    localparam int AXIS_OFS_W  = 2;

    typedef enum logic {
        ARB_IDLE,
        ARB_XFER
    } arb_state_t;

    // Scans ptr+1, ptr+2, ... modulo n; the port at ptr itself is checked last.
    function automatic int unsigned rr_pick(input logic [7:0] req,
                                            input int unsigned ptr,
                                            input int unsigned n);
        int unsigned w_win;
        int unsigned w_idx;
        logic        w_found;
        w_win   = 0;
        w_found = 1'b0;
        for (int unsigned k = 1; k <= 8; k++) begin
            w_idx = (ptr + k) % n;
            if (k <= n && !w_found && req[w_idx[2:0]]) begin
                w_win   = w_idx;
                w_found = 1'b1;
            end
        end
        return w_win;
    endfunction

endpackage

// File: rtl/axis_skid.sv
// Two-entry skid buffer: registered outputs, full throughput, and an upstream
// ready that depends only on the skid register so it never chains combinationally.
module axis_skid #(
    parameter int WIDTH = 41
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_valid,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_ready,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data,
    input  logic             i_ready
);

    logic             r_out_vld;
    logic             r_skid_vld;
    logic [WIDTH-1:0] r_out_data;
    logic [WIDTH-1:0] r_skid_data;

    assign o_ready = !r_skid_vld;
    assign o_valid = r_out_vld;
    assign o_data  = r_out_data;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_out_vld   <= 1'b0;
            r_skid_vld  <= 1'b0;
            r_out_data  <= '0;
            r_skid_data <= '0;
        end else if (!r_out_vld || i_ready) begin
            // Output slot frees up: drain the skid first, otherwise take the input.
            if (r_skid_vld) begin
                r_out_vld  <= 1'b1;
                r_out_data <= r_skid_data;
                r_skid_vld <= 1'b0;
            end else begin
                r_out_vld <= i_valid;
                if (i_valid) begin
                    r_out_data <= i_data;
                end
            end
        end else if (i_valid && !r_skid_vld) begin
            r_skid_vld  <= 1'b1;
            r_skid_data <= i_data;
        end
    end

endmodule

// File: rtl/axis_realign_arb.sv
// Packet-level round-robin arbiter feeding a single axis_realign instance; the
// winner's byte offset is latched at grant and travels with every beat.
module axis_realign_arb
    import axis_pkg::*;
#(
    parameter int N_PORTS = 4,
    parameter int ID_W    = 2,
    parameter int DATA_W  = AXIS_DATA_W
) (
    input  logic                         aclk,
    input  logic                         aresetn,
    input  logic [N_PORTS*DATA_W-1:0]    s_tdata,
    input  logic [N_PORTS*DATA_W/8-1:0]  s_tkeep,
    input  logic [N_PORTS-1:0]           s_tlast,
    input  logic [N_PORTS-1:0]           s_tvalid,
    input  logic [N_PORTS*AXIS_OFS_W-1:0] s_tuser,
    output logic [N_PORTS-1:0]           s_tready,
    input  logic [N_PORTS-1:0]           port_en,
    output logic [DATA_W-1:0]            m_tdata,
    output logic [DATA_W/8-1:0]          m_tkeep,
    output logic                         m_tlast,
    output logic                         m_tvalid,
    output logic [AXIS_OFS_W-1:0]        m_tuser,
    output logic [ID_W-1:0]              m_tid,
    input  logic                         m_tready,
    output logic                         busy
);

    localparam int KEEP_W = DATA_W / 8;
    localparam int OFS_W  = AXIS_OFS_W;
    localparam int PW     = DATA_W + KEEP_W + 1 + OFS_W + ID_W;

    arb_state_t        r_state;
    logic [ID_W-1:0]   r_grant;
    logic [ID_W-1:0]   r_rr_ptr;
    logic [OFS_W-1:0]  r_ofs;
    logic              r_busy;

    logic [N_PORTS-1:0] w_req;
    logic [7:0]         w_req8;
    logic [ID_W-1:0]    w_pick;
    logic [OFS_W-1:0]   w_pick_ofs;
    logic [DATA_W-1:0]  w_cur_data;
    logic [KEEP_W-1:0]  w_cur_keep;
    logic               w_cur_last;
    logic               w_cur_valid;
    logic               w_skid_in_valid;
    logic               w_skid_in_ready;
    logic               w_hs;
    logic [PW-1:0]      w_skid_in;
    logic [PW-1:0]      w_skid_out;

    assign w_req = s_tvalid & port_en;

    always_comb begin
        w_req8              = '0;
        w_req8[N_PORTS-1:0] = w_req;
    end

    assign w_pick = ID_W'(rr_pick(w_req8, 32'(r_rr_ptr), N_PORTS));

    // Two muxes: the offset of the candidate winner, and the locked source's beat.
    always_comb begin
        w_pick_ofs  = '0;
        w_cur_data  = '0;
        w_cur_keep  = '0;
        w_cur_last  = 1'b0;
        w_cur_valid = 1'b0;
        for (int i = 0; i < N_PORTS; i++) begin
            if (w_pick == ID_W'(i)) begin
                w_pick_ofs = s_tuser[OFS_W*i +: OFS_W];
            end
            if (r_grant == ID_W'(i)) begin
                w_cur_data  = s_tdata[DATA_W*i +: DATA_W];
                w_cur_keep  = s_tkeep[KEEP_W*i +: KEEP_W];
                w_cur_last  = s_tlast[i];
                w_cur_valid = s_tvalid[i];
            end
        end
    end

    assign w_skid_in_valid = (r_state == ARB_XFER) && w_cur_valid;
    assign w_hs            = w_skid_in_valid && w_skid_in_ready;

    always_comb begin
        s_tready = '0;
        if (r_state == ARB_XFER) begin
            for (int i = 0; i < N_PORTS; i++) begin
                if (r_grant == ID_W'(i)) begin
                    s_tready[i] = w_skid_in_ready;
                end
            end
        end
    end

    // port_en only gates new grants; an active packet always runs to its tlast.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state  <= ARB_IDLE;
            r_grant  <= '0;
            r_rr_ptr <= ID_W'(N_PORTS - 1);
            r_ofs    <= '0;
            r_busy   <= 1'b0;
        end else begin
            case (r_state)
                ARB_IDLE: begin
                    if (|w_req) begin
                        r_grant  <= w_pick;
                        r_rr_ptr <= w_pick;
                        r_ofs    <= w_pick_ofs;
                        r_state  <= ARB_XFER;
                        r_busy   <= 1'b1;
                    end
                end
                ARB_XFER: begin
                    if (w_hs && w_cur_last) begin
                        r_state <= ARB_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ARB_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign w_skid_in = {w_cur_data, w_cur_keep, w_cur_last, r_ofs, r_grant};

    axis_skid #(
        .WIDTH (PW)
    ) u_skid (
        .i_clk   (aclk),
        .i_rst_n (aresetn),
        .i_valid (w_skid_in_valid),
        .i_data  (w_skid_in),
        .o_ready (w_skid_in_ready),
        .o_valid (m_tvalid),
        .o_data  (w_skid_out),
        .i_ready (m_tready)
    );

    assign {m_tdata, m_tkeep, m_tlast, m_tuser, m_tid} = w_skid_out;
    assign busy = r_busy;

endmodule

// File: tb/tb_axis_realign_arb.sv
// Directed bench for axis_realign_arb: per-port packet sources, an output beat
// recorder, and one task per scenario with hand-derived expectations.
module tb_axis_realign_arb;

    localparam int NP  = 4;
    localparam int IDW = 2;
    localparam int DW  = 32;
    localparam int MAXB = 64;

    logic              aclk = 1'b0;
    logic              aresetn;
    logic [NP*DW-1:0]  s_tdata;
    logic [NP*4-1:0]   s_tkeep;
    logic [NP-1:0]     s_tlast;
    logic [NP-1:0]     s_tvalid;
    logic [NP*2-1:0]   s_tuser;
    logic [NP-1:0]     s_tready;
    logic [NP-1:0]     port_en;
    logic [DW-1:0]     m_tdata;
    logic [3:0]        m_tkeep;
    logic              m_tlast;
    logic              m_tvalid;
    logic [1:0]        m_tuser;
    logic [IDW-1:0]    m_tid;
    logic              m_tready;
    logic              busy;

    axis_realign_arb #(
        .N_PORTS (NP),
        .ID_W    (IDW),
        .DATA_W  (DW)
    ) dut (
        .aclk     (aclk),
        .aresetn  (aresetn),
        .s_tdata  (s_tdata),
        .s_tkeep  (s_tkeep),
        .s_tlast  (s_tlast),
        .s_tvalid (s_tvalid),
        .s_tuser  (s_tuser),
        .s_tready (s_tready),
        .port_en  (port_en),
        .m_tdata  (m_tdata),
        .m_tkeep  (m_tkeep),
        .m_tlast  (m_tlast),
        .m_tvalid (m_tvalid),
        .m_tuser  (m_tuser),
        .m_tid    (m_tid),
        .m_tready (m_tready),
        .busy     (busy)
    );

    always #5 aclk = ~aclk;

    int n_tests;
    int n_fail;
    int cyc;

    int         src_len   [NP];
    int         src_beat  [NP];
    int         src_npkts [NP];
    int         src_pkt   [NP];
    logic [1:0] src_ofs   [NP];
    logic [3:0] src_keep  [NP];

    int         mon_n;
    logic [31:0] mon_data [MAXB];
    logic [3:0]  mon_keep [MAXB];
    logic        mon_last [MAXB];
    logic [1:0]  mon_user [MAXB];
    logic [1:0]  mon_tid  [MAXB];
    int          mon_cyc  [MAXB];

    logic        smp_mvalid;
    logic [31:0] smp_mdata;
    logic [NP-1:0] smp_sready;
    logic        smp_busy;

    function automatic logic [31:0] beat_data(input int port, input int pkt, input int beat);
        return {port[3:0], 4'h0, pkt[7:0], beat[15:0]};
    endfunction

    task automatic drive_srcs();
        for (int i = 0; i < NP; i++) begin
            s_tvalid[i]          = (src_npkts[i] > 0);
            s_tdata[32*i +: 32]  = beat_data(i, src_pkt[i], src_beat[i]);
            s_tkeep[4*i +: 4]    = src_keep[i];
            s_tlast[i]           = (src_beat[i] == src_len[i] - 1);
            s_tuser[2*i +: 2]    = src_ofs[i];
        end
    endtask

    task automatic clear_srcs();
        for (int i = 0; i < NP; i++) begin
            src_len[i]   = 1;
            src_beat[i]  = 0;
            src_npkts[i] = 0;
            src_pkt[i]   = 0;
            src_ofs[i]   = 2'd0;
            src_keep[i]  = 4'hF;
        end
        drive_srcs();
    endtask

    // Sample mid-cycle, then advance sources just after the rising edge.
    task automatic tick();
        logic [NP-1:0] acc;
        @(negedge aclk);
        smp_mvalid = m_tvalid;
        smp_mdata  = m_tdata;
        smp_sready = s_tready;
        smp_busy   = busy;
        if (m_tvalid && m_tready && mon_n < MAXB) begin
            mon_data[mon_n] = m_tdata;
            mon_keep[mon_n] = m_tkeep;
            mon_last[mon_n] = m_tlast;
            mon_user[mon_n] = m_tuser;
            mon_tid[mon_n]  = m_tid;
            mon_cyc[mon_n]  = cyc;
            mon_n++;
        end
        acc = s_tvalid & s_tready;
        @(posedge aclk);
        #1;
        cyc++;
        for (int i = 0; i < NP; i++) begin
            if (acc[i]) begin
                if (src_beat[i] == src_len[i] - 1) begin
                    src_beat[i] = 0;
                    src_npkts[i]--;
                    src_pkt[i]++;
                end else begin
                    src_beat[i]++;
                end
            end
        end
        drive_srcs();
    endtask

    task automatic apply_reset();
        aresetn  = 1'b0;
        m_tready = 1'b1;
        port_en  = '1;
        clear_srcs();
        mon_n = 0;
        tick();
        tick();
        aresetn = 1'b1;
    endtask

    task automatic run_until(input int nbeats, input int budget);
        for (int k = 0; k < budget && mon_n < nbeats; k++) tick();
    endtask

    task automatic test_reset();
        aresetn = 1'b0;
        src_len[0]   = 2;
        src_npkts[0] = 1;
        src_ofs[0]   = 2'd3;
        drive_srcs();
        tick();
        tick();
        n_tests++;
        if (smp_sready !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_s_tready: got %b expected 0000", smp_sready);
        end
        n_tests++;
        if (smp_mvalid !== 1'b0 || smp_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_valid_busy: got %b%b expected 00", smp_mvalid, smp_busy);
        end
        n_tests++;
        if ({m_tlast, m_tuser, m_tid} !== 5'd0) begin
            n_fail++;
            $display("FAIL reset_sideband: got %b expected 00000", {m_tlast, m_tuser, m_tid});
        end
    endtask

    task automatic test_single();
        int c0;
        logic [40:0] got, exp;
        apply_reset();
        src_len[0]   = 3;
        src_npkts[0] = 1;
        src_ofs[0]   = 2'd2;
        drive_srcs();
        c0 = cyc;
        tick();
        n_tests++;
        if ({smp_busy, smp_sready} !== 5'b0_0000) begin
            n_fail++;
            $display("FAIL t1_decision: got %b expected 00000", {smp_busy, smp_sready});
        end
        tick();
        n_tests++;
        if ({smp_busy, smp_sready} !== 5'b1_0001) begin
            n_fail++;
            $display("FAIL t1_xfer: got %b expected 10001", {smp_busy, smp_sready});
        end
        run_until(3, 20);
        tick();
        tick();
        n_tests++;
        if (mon_n !== 3) begin
            n_fail++;
            $display("FAIL t1_count: got %0d expected 3", mon_n);
        end
        for (int b = 0; b < 3 && b < mon_n; b++) begin
            got = {mon_tid[b], mon_user[b], mon_last[b], mon_keep[b], mon_data[b]};
            exp = {2'd0, 2'd2, (b == 2), 4'hF, beat_data(0, 0, b)};
            n_tests++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL t1_beat%0d: got %h expected %h", b, got, exp);
            end
        end
        n_tests++;
        if (mon_n < 3 || mon_cyc[0] - c0 !== 2 || mon_cyc[2] - mon_cyc[0] !== 2) begin
            n_fail++;
            $display("FAIL t1_timing: got first=%0d span=%0d expected 2 2",
                     mon_cyc[0] - c0, mon_cyc[2] - mon_cyc[0]);
        end
        n_tests++;
        if (smp_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL t1_busy_end: got %b expected 0", smp_busy);
        end
    endtask

    task automatic test_round_robin();
        logic [40:0] got, exp;
        int t, bad_gap;
        apply_reset();
        for (int i = 0; i < NP; i++) begin
            src_len[i]   = 2;
            src_npkts[i] = 2;
            src_ofs[i]   = 2'(i);
            src_keep[i]  = 4'hF >> i;
        end
        drive_srcs();
        run_until(16, 80);
        n_tests++;
        if (mon_n !== 16) begin
            n_fail++;
            $display("FAIL t2_count: got %0d expected 16", mon_n);
        end
        for (int k = 0; k < 16 && k < mon_n; k++) begin
            t   = (k / 2) % 4;
            got = {mon_tid[k], mon_user[k], mon_last[k], mon_keep[k], mon_data[k]};
            exp = {2'(t), 2'(t), (k % 2 == 1), 4'hF >> t, beat_data(t, k / 8, k % 2)};
            n_tests++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL t2_beat%0d: got %h expected %h", k, got, exp);
            end
        end
        bad_gap = 0;
        for (int p = 0; p < 7 && 2 * p + 2 < mon_n; p++) begin
            if (mon_cyc[2*p+1] - mon_cyc[2*p] != 1 || mon_cyc[2*p+2] - mon_cyc[2*p+1] != 2)
                bad_gap++;
        end
        n_tests++;
        if (bad_gap !== 0) begin
            n_fail++;
            $display("FAIL t2_bubble: got %0d bad gaps expected 0", bad_gap);
        end
    endtask

    task automatic test_backpressure();
        logic stable_ok;
        apply_reset();
        src_len[0]   = 4;
        src_npkts[0] = 1;
        src_ofs[0]   = 2'd1;
        drive_srcs();
        tick();
        tick();
        tick();
        n_tests++;
        if (mon_n !== 1) begin
            n_fail++;
            $display("FAIL t3_first: got %0d beats expected 1", mon_n);
        end
        m_tready = 1'b0;
        tick();
        n_tests++;
        if (smp_mvalid !== 1'b1 || smp_mdata !== beat_data(0, 0, 1)) begin
            n_fail++;
            $display("FAIL t3_hold_beat: got %b %h expected 1 %h", smp_mvalid, smp_mdata, beat_data(0, 0, 1));
        end
        tick();
        n_tests++;
        if (smp_sready !== 4'b0000) begin
            n_fail++;
            $display("FAIL t3_stall_ready: got %b expected 0000", smp_sready);
        end
        stable_ok = (smp_mvalid === 1'b1) && (smp_mdata === beat_data(0, 0, 1));
        for (int k = 0; k < 3; k++) begin
            tick();
            if (smp_mvalid !== 1'b1 || smp_mdata !== beat_data(0, 0, 1) || smp_sready !== 4'b0000)
                stable_ok = 1'b0;
        end
        n_tests++;
        if (stable_ok !== 1'b1) begin
            n_fail++;
            $display("FAIL t3_stable: got %b expected 1", stable_ok);
        end
        m_tready = 1'b1;
        run_until(4, 20);
        tick();
        tick();
        n_tests++;
        if (mon_n !== 4) begin
            n_fail++;
            $display("FAIL t3_count: got %0d expected 4", mon_n);
        end
        for (int b = 0; b < 4 && b < mon_n; b++) begin
            n_tests++;
            if ({mon_last[b], mon_user[b], mon_data[b]} !== {(b == 3), 2'd1, beat_data(0, 0, b)}) begin
                n_fail++;
                $display("FAIL t3_beat%0d: got %h expected %h", b,
                         {mon_last[b], mon_user[b], mon_data[b]}, {(b == 3), 2'd1, beat_data(0, 0, b)});
            end
        end
    endtask

    task automatic test_mask_tuser();
        logic [40:0] got, exp;
        apply_reset();
        src_len[1]   = 3;
        src_npkts[1] = 2;
        src_ofs[1]   = 2'd1;
        src_len[2]   = 2;
        src_npkts[2] = 1;
        src_ofs[2]   = 2'd0;
        drive_srcs();
        tick();
        tick();
        port_en[1] = 1'b0;
        src_ofs[1] = 2'd3;
        drive_srcs();
        run_until(5, 40);
        for (int k = 0; k < 10; k++) tick();
        n_tests++;
        if (mon_n !== 5) begin
            n_fail++;
            $display("FAIL t4_count: got %0d expected 5", mon_n);
        end
        for (int b = 0; b < 5 && b < mon_n; b++) begin
            got = {mon_tid[b], mon_user[b], mon_last[b], mon_keep[b], mon_data[b]};
            if (b < 3) exp = {2'd1, 2'd1, (b == 2), 4'hF, beat_data(1, 0, b)};
            else       exp = {2'd2, 2'd0, (b == 4), 4'hF, beat_data(2, 0, b - 3)};
            n_tests++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL t4_beat%0d: got %h expected %h", b, got, exp);
            end
        end
        n_tests++;
        if (src_npkts[1] !== 1 || smp_busy !== 1'b0 || smp_sready !== 4'b0000) begin
            n_fail++;
            $display("FAIL t4_masked_idle: got pkts=%0d busy=%b ready=%b expected 1 0 0000",
                     src_npkts[1], smp_busy, smp_sready);
        end
    endtask

    task automatic test_wrap();
        logic [40:0] got, exp;
        apply_reset();
        src_npkts[0] = 1;
        src_ofs[0]   = 2'd3;
        src_npkts[2] = 1;
        src_ofs[2]   = 2'd1;
        src_keep[2]  = 4'b0011;
        drive_srcs();
        run_until(2, 20);
        n_tests++;
        if (mon_n !== 2) begin
            n_fail++;
            $display("FAIL t5_count: got %0d expected 2", mon_n);
        end
        if (mon_n >= 2) begin
            got = {mon_tid[0], mon_user[0], mon_last[0], mon_keep[0], mon_data[0]};
            exp = {2'd0, 2'd3, 1'b1, 4'hF, beat_data(0, 0, 0)};
            n_tests++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL t5_first: got %h expected %h", got, exp);
            end
            got = {mon_tid[1], mon_user[1], mon_last[1], mon_keep[1], mon_data[1]};
            exp = {2'd2, 2'd1, 1'b1, 4'b0011, beat_data(2, 0, 0)};
            n_tests++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL t5_second: got %h expected %h", got, exp);
            end
            n_tests++;
            if (mon_cyc[1] - mon_cyc[0] !== 2) begin
                n_fail++;
                $display("FAIL t5_single_gap: got %0d expected 2", mon_cyc[1] - mon_cyc[0]);
            end
        end
        src_npkts[0] = 1;
        src_npkts[1] = 1;
        src_npkts[3] = 1;
        drive_srcs();
        run_until(5, 30);
        n_tests++;
        if (mon_n !== 5 || {mon_tid[2], mon_tid[3], mon_tid[4]} !== {2'd3, 2'd0, 2'd1}) begin
            n_fail++;
            $display("FAIL t5_wrap_order: got n=%0d ids=%h expected n=5 ids=%h",
                     mon_n, {mon_tid[2], mon_tid[3], mon_tid[4]}, {2'd3, 2'd0, 2'd1});
        end
    endtask

    task automatic test_async_reset();
        logic [40:0] got, exp;
        apply_reset();
        src_len[0]   = 4;
        src_npkts[0] = 1;
        src_ofs[0]   = 2'd2;
        drive_srcs();
        tick();
        tick();
        tick();
        aresetn = 1'b0;
        #1;
        n_tests++;
        if ({s_tready, m_tvalid, busy} !== 6'd0) begin
            n_fail++;
            $display("FAIL t6_async_clear: got %b expected 000000", {s_tready, m_tvalid, busy});
        end
        n_tests++;
        if ({m_tuser, m_tid, m_tlast} !== 5'd0) begin
            n_fail++;
            $display("FAIL t6_async_side: got %b expected 00000", {m_tuser, m_tid, m_tlast});
        end
        src_beat[0]  = 0;
        src_pkt[0]   = 1;
        src_npkts[0] = 1;
        src_len[1]   = 2;
        src_npkts[1] = 1;
        src_ofs[1]   = 2'd1;
        drive_srcs();
        tick();
        tick();
        mon_n   = 0;
        aresetn = 1'b1;
        run_until(6, 40);
        n_tests++;
        if (mon_n !== 6) begin
            n_fail++;
            $display("FAIL t6_count: got %0d expected 6", mon_n);
        end
        for (int b = 0; b < 6 && b < mon_n; b++) begin
            got = {mon_tid[b], mon_user[b], mon_last[b], mon_keep[b], mon_data[b]};
            if (b < 4) exp = {2'd0, 2'd2, (b == 3), 4'hF, beat_data(0, 1, b)};
            else       exp = {2'd1, 2'd1, (b == 5), 4'hF, beat_data(1, 0, b - 4)};
            n_tests++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL t6_beat%0d: got %h expected %h", b, got, exp);
            end
        end
    endtask

    initial begin
        n_tests  = 0;
        n_fail   = 0;
        cyc      = 0;
        mon_n    = 0;
        aresetn  = 1'b1;
        m_tready = 1'b1;
        port_en  = '1;
        clear_srcs();
        #2;
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_mask_tuser();
        test_wrap();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
